// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared state encoding, counter width and index-width helper
package dmem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int CNT_W = 4;
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array: single-port word storage with synchronous write and registered read
module dmem_word_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // read register only moves on a read so the last load data stays put
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder with programmable wait states
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = idx_width(DEPTH_WORDS);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic we_q, ld_q, accept, commit, cur_we, err;
  logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, rd;
  // with zero latency the commit happens on the accept edge, so the live request is used in IDLE
  always_comb begin
    req_ready = state == IDLE && !reset;
    accept = req_valid && req_ready;
    cur_we = state == IDLE ? req_we : we_q;
    cur_addr = state == IDLE ? req_addr : addr_q;
    cur_wdata = state == IDLE ? req_wdata : wdata_q;
    err = cur_addr[1:0] != 2'b0 || {2'b0, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
    commit = !reset && (state == IDLE ? accept && LATENCY == 0 : state == WAIT && cnt == CNT_W'(1));
    rsp_valid = state == RESP;
    rsp_rdata = ld_q ? rd : '0;
  end
  // request latches, wait counter, response flags and the IDLE/WAIT/RESP sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ld_q <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= CNT_W'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (commit) begin
        ld_q <= !cur_we && !err;
        rsp_err <= err;
      end
      state <= commit ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
    end
  end
  dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_array (
    .clk(clk),
    .we(commit && cur_we && !err),
    .re(commit && !cur_we && !err),
    .addr(cur_addr[IW+1:2]),
    .wdata(cur_wdata),
    .rdata(rd)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized check of two responders (LATENCY 2 and 0) against a word-array model
module tb_dmem_responder;
  logic clk = 0;
  logic reset;
  logic rv [2];
  logic rwe [2];
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  logic ready [2];
  logic rspv [2];
  logic rerr [2];
  logic [31:0] rrd [2];
  logic [31:0] mdl [2][256];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(ready[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rspv[0]), .rsp_rdata(rrd[0]), .rsp_err(rerr[0])
  );
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(ready[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rspv[1]), .rsp_rdata(rrd[1]), .rsp_err(rerr[1])
  );

  function automatic int lat(input int d);
    return d == 0 ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // one full transaction; entered and left just after a rising edge
  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd, input bit scramble);
    int n;
    bit e;
    logic [31:0] want;
    n = 0;
    while (!ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(ready[d]), 32'd1);
    rv[d] = 1; rwe[d] = we; ra[d] = a; rwd[d] = wd;
    @(posedge clk); #1;
    rv[d] = 0;
    if (scramble) begin
      rwe[d] = ~we; ra[d] = $urandom; rwd[d] = $urandom;
    end
    e = a[1:0] != 2'b0 || (a >> 2) >= 256;
    want = (!we && !e) ? mdl[d][a[9:2]] : 32'h0;
    if (we && !e) mdl[d][a[9:2]] = wd;
    n = 1;
    @(negedge clk);
    while (!rspv[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat(d) + 1));
    chk("rdata", rrd[d], want);
    chk("err", 32'(rerr[d]), 32'(e));
    @(negedge clk);
    chk("pulse_end", 32'(rspv[d]), 32'd0);
    chk("rdata_held", rrd[d], want);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; rwe[d] = 0; ra[d] = 0; rwd[d] = 0;
      for (int i = 0; i < 256; i++) mdl[d][i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(rspv[d]), 32'd0);
      chk("rst_rdata", rrd[d], 32'd0);
      chk("rst_err", 32'(rerr[d]), 32'd0);
      chk("rst_ready", 32'(ready[d]), 32'd0);
    end
    reset = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready[0]), 32'd1);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) txn(d, 1'b1, 32'(i * 4), 32'h0, 1'b0);
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("deadbeef", rrd[0], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(i * 4), $urandom, 1'b0);
    rv[1] = 1; rwe[1] = 0; ra[1] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(ready[1]), 32'(i % 2 == 0));
      chk("b2b_valid", 32'(rspv[1]), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("b2b_rdata", rrd[1], mdl[1][(i - 1) / 2]);
      @(posedge clk); #1;
      if (i % 2 == 0) ra[1] = 32'(4 * (i / 2 + 1));
    end
    rv[1] = 0;
    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b0, 32'h13, 32'h0, 1'b0);
      txn(d, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
      txn(d, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    txn(0, 1'b1, 32'h44, 32'h0BADF00D, 1'b1);
    txn(0, 1'b0, 32'h44, 32'h0, 1'b1);
    rv[0] = 1; rwe[0] = 1; ra[0] = 32'h20; rwd[0] = 32'h12345678;
    @(posedge clk); #1;
    rv[0] = 0; reset = 1;
    @(negedge clk);
    chk("rst_wait_valid", 32'(rspv[0]), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_wait_norsp", 32'(rspv[0]), 32'd0);
    end
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("rst_wait_nowrite", rrd[0], 32'h0);
    rv[0] = 1; rwe[0] = 1; ra[0] = 32'h8; rwd[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rv[0] = 0;
    n = 0;
    @(negedge clk);
    while (!rspv[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_seen", 32'(rspv[0]), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_resp_drop", 32'(rspv[0]), 32'd0);
    mdl[0][2] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0);
    chk("rst_resp_kept", rrd[0], 32'hA5A5A5A5);
    for (int k = 0; k < 300; k++) begin
      case ($urandom % 8)
        0: a = {$urandom_range(0, 255) == 0 ? 22'h0 : 22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
        1: a = 32'h400 + 32'($urandom_range(0, 255) * 4) + (($urandom % 2) == 0 ? 32'h0 : 32'h10000);
        default: a = {22'h0, 8'($urandom), 2'b00};
      endcase
      txn(int'($urandom % 2), 1'($urandom), a, $urandom, 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
